// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the round-robin demux feeder.
package demux_pkg;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        SEND   = 2'd2
    } sched_state_t;
endpackage

// File: rtl/rr_next_channel.sv
// Rotating priority search: first enabled channel after ptr, wrapping back to ptr itself.
module rr_next_channel
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]  ptr,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [SEL_W-1:0]  next,
    output logic              found
);

    // Walk from farthest to nearest so the nearest enabled channel wins.
    always_comb begin
        next  = ptr;
        found = 1'b0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (ch_en[SEL_W'(32'(ptr) + i)]) begin
                next  = SEL_W'(32'(ptr) + i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Cuts a valid/ready serial bit stream into FRAME_LEN-bit frames and steers each
// frame to the next enabled demux channel in round-robin order.
module demux_rr_scheduler
    import demux_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = 8,
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [SEL_W-1:0]  sel,
    output logic              x,
    output logic              out_valid,
    output logic              frame_done
);

    sched_state_t     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             x_q, x_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;

    logic [SEL_W-1:0] rr_next;
    logic             rr_found;
    logic             xfer;

    rr_next_channel u_rr (
        .ptr   (ptr_q),
        .ch_en (ch_en),
        .next  (rr_next),
        .found (rr_found)
    );

    assign in_ready = (state_q == SEND);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        bit_cnt_d    = bit_cnt_q;
        x_d          = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|ch_en) state_d = SELECT;
            end
            SELECT: begin
                if (rr_found) begin
                    sel_d     = rr_next;
                    bit_cnt_d = '0;
                    state_d   = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (xfer) begin
                    x_d         = in_bit;
                    out_valid_d = 1'b1;
                    // Last bit: hand the pointer over and take the bubble cycle in SELECT.
                    if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        frame_done_d = 1'b1;
                        ptr_d        = sel_q;
                        state_d      = SELECT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            ptr_q        <= SEL_W'(NUM_CH - 1);
            bit_cnt_q    <= '0;
            x_q          <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            bit_cnt_q    <= bit_cnt_d;
            x_q          <= x_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign x          = x_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule
